read_stage: RTL and testbench

- Parametrised second pipeline stage: decodes the 16-bit instruction and drives register-file read addresses.
- Resolves RAW hazards by forwarding from NUM_FWD downstream stages; inserts bubbles on load-use.
- Registers the decoded operands into a single-entry output slot with valid/ready handshake; replaces the fixed stall input with backpressure and flush.
- Sits between the fetch stage and the execute unit.

---
 rtl/read_stage_pkg.sv | 153 +++++++++++++++
 rtl/read_stage_fwd_mux.sv | 51 +++++
 rtl/read_stage.sv | 159 +++++++++++++++
 tb/tb_read_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/read_stage_pkg.sv
// Shared instruction-format definitions for the read stage: type/opcode codes,
// field widths and bit positions, and the field decoder used by the top.
package read_stage_pkg;

   localparam int INSTRUCTION_SIZE = 16;
   localparam int REG_ADDR_SIZE    = 3;

   localparam int OPCODE_SIZE    = 4;
   localparam int VALUE_SIZE     = 6;
   localparam int CONSTANT_SIZE  = 8;
   localparam int OFFSET_SIZE    = 6;
   localparam int CONDITION_SIZE = 3;

   // The top two opcode bits pick the instruction class; the low two pick the variant.
   localparam int INST_SELECT_MSB          = 15;
   localparam int INST_SELECT_LSB          = 14;
   localparam int OPCODE_SELECT_MSB        = 15;
   localparam int OPCODE_SELECT_LSB        = 12;
   localparam int MEMORY_ACCESS_SELECT_MSB = 13;
   localparam int MEMORY_ACCESS_SELECT_LSB = 12;
   localparam int JUMP_SELECT_MSB          = 13;
   localparam int JUMP_SELECT_LSB          = 12;
   localparam int CONDITION_MSB            = 11;
   localparam int CONDITION_LSB            = 9;

   localparam int ARITH_SRC0_LSB = 3;
   localparam int ARITH_SRC1_LSB = 0;
   localparam int ARITH_DEST_LSB = 6;
   localparam int SHIFT_SRC0_LSB = 6;
   localparam int SHIFT_DEST_LSB = 6;
   localparam int MEM_SRC0_LSB   = 0;
   localparam int MEM_DEST_LSB   = 8;
   localparam int JMP_SRC0_LSB   = 0;
   localparam int JCOND_SRC0_LSB = 6;
   localparam int JCOND_SRC1_LSB = 0;

   typedef enum logic [1:0] {
      INST_ARITH  = 2'b00,
      INST_SHIFT  = 2'b01,
      INST_MEMORY = 2'b10,
      INST_JUMP   = 2'b11
   } inst_type_t;

   typedef enum logic [1:0] {
      MEM_LOAD     = 2'b00,
      MEM_STORE    = 2'b01,
      MEM_LOADC    = 2'b10,
      MEM_RESERVED = 2'b11
   } mem_type_t;

   typedef enum logic [1:0] {
      JUMP_JMP      = 2'b00,
      JUMP_JMPR     = 2'b01,
      JUMP_JMPCOND  = 2'b10,
      JUMP_JMPRCOND = 2'b11
   } jump_type_t;

   localparam logic [OPCODE_SIZE-1:0] OP_ADD      = 4'h0;
   localparam logic [OPCODE_SIZE-1:0] OP_SUB      = 4'h1;
   localparam logic [OPCODE_SIZE-1:0] OP_AND      = 4'h2;
   localparam logic [OPCODE_SIZE-1:0] OP_OR       = 4'h3;
   localparam logic [OPCODE_SIZE-1:0] OP_SHL      = 4'h4;
   localparam logic [OPCODE_SIZE-1:0] OP_SHR      = 4'h5;
   localparam logic [OPCODE_SIZE-1:0] OP_LOAD     = 4'h8;
   localparam logic [OPCODE_SIZE-1:0] OP_STORE    = 4'h9;
   localparam logic [OPCODE_SIZE-1:0] OP_LOADC    = 4'hA;
   localparam logic [OPCODE_SIZE-1:0] OP_JMP      = 4'hC;
   localparam logic [OPCODE_SIZE-1:0] OP_JMPR     = 4'hD;
   localparam logic [OPCODE_SIZE-1:0] OP_JMPCOND  = 4'hE;
   localparam logic [OPCODE_SIZE-1:0] OP_JMPRCOND = 4'hF;

   localparam logic [INSTRUCTION_SIZE-1:0] NOP = 16'h0000;

   typedef enum logic [2:0] {
      KIND_ARITH,
      KIND_SHIFT,
      KIND_LOADSTORE,
      KIND_LOADC,
      KIND_JMP,
      KIND_JMPR,
      KIND_JMPCOND,
      KIND_JMPRCOND
   } kind_t;

   typedef struct packed {
      kind_t                    kind;
      logic [REG_ADDR_SIZE-1:0] src0;
      logic [REG_ADDR_SIZE-1:0] src1;
      logic [REG_ADDR_SIZE-1:0] dest;
      logic                     use0;
      logic                     use1;
   } decode_t;

   // Unused sources stay at register 0 so the read ports idle at address 0.
   function automatic decode_t decode_instruction(input logic [INSTRUCTION_SIZE-1:0] inst);
      decode_t d;
      d      = '0;
      d.kind = KIND_ARITH;
      case (inst[INST_SELECT_MSB:INST_SELECT_LSB])
         INST_ARITH: begin
            d.kind = KIND_ARITH;
            d.src0 = inst[ARITH_SRC0_LSB +: REG_ADDR_SIZE];
            d.src1 = inst[ARITH_SRC1_LSB +: REG_ADDR_SIZE];
            d.dest = inst[ARITH_DEST_LSB +: REG_ADDR_SIZE];
            d.use0 = 1'b1;
            d.use1 = 1'b1;
         end
         INST_SHIFT: begin
            d.kind = KIND_SHIFT;
            d.src0 = inst[SHIFT_SRC0_LSB +: REG_ADDR_SIZE];
            d.dest = inst[SHIFT_DEST_LSB +: REG_ADDR_SIZE];
            d.use0 = 1'b1;
         end
         INST_MEMORY: begin
            d.dest = inst[MEM_DEST_LSB +: REG_ADDR_SIZE];
            if (inst[MEMORY_ACCESS_SELECT_MSB:MEMORY_ACCESS_SELECT_LSB] == MEM_LOADC) begin
               d.kind = KIND_LOADC;
            end else begin
               d.kind = KIND_LOADSTORE;
               d.src0 = inst[MEM_SRC0_LSB +: REG_ADDR_SIZE];
               d.use0 = 1'b1;
            end
         end
         INST_JUMP: begin
            case (inst[JUMP_SELECT_MSB:JUMP_SELECT_LSB])
               JUMP_JMP: begin
                  d.kind = KIND_JMP;
                  d.src0 = inst[JMP_SRC0_LSB +: REG_ADDR_SIZE];
                  d.use0 = 1'b1;
               end
               JUMP_JMPR: begin
                  d.kind = KIND_JMPR;
               end
               JUMP_JMPCOND: begin
                  d.kind = KIND_JMPCOND;
                  d.src0 = inst[JCOND_SRC0_LSB +: REG_ADDR_SIZE];
                  d.src1 = inst[JCOND_SRC1_LSB +: REG_ADDR_SIZE];
                  d.use0 = 1'b1;
                  d.use1 = 1'b1;
               end
               default: begin
                  d.kind = KIND_JMPRCOND;
                  d.src0 = inst[JCOND_SRC0_LSB +: REG_ADDR_SIZE];
                  d.use0 = 1'b1;
               end
            endcase
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/read_stage_fwd_mux.sv
// Operand source selection for one register read: picks forwarded data from the
// youngest ready producer, otherwise register-file data, and flags load-use.
module read_stage_fwd_mux
   import read_stage_pkg::*;
#(
   parameter int DATA_SIZE = 32,
   parameter int NUM_FWD   = 2
) (
   input  logic [REG_ADDR_SIZE-1:0]     src,
   input  logic                         used,
   input  logic [DATA_SIZE-1:0]         read_data,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD-1:0]           fwd_pending,
   input  logic [NUM_FWD*3-1:0]         fwd_address,
   input  logic [NUM_FWD*DATA_SIZE-1:0] fwd_data,
   output logic [DATA_SIZE-1:0]         data,
   output logic                         hazard
);

   logic match_found;
   logic match_pending;
   logic ready_found;
   logic [DATA_SIZE-1:0] ready_data;

   // Scan from the youngest source; the first match decides the hazard, while
   // the first non-pending match supplies the data.
   always_comb begin
      match_found   = 1'b0;
      match_pending = 1'b0;
      ready_found   = 1'b0;
      ready_data    = '0;
      for (int i = 0; i < NUM_FWD; i++) begin
         if (fwd_valid[i] && (fwd_address[3*i +: 3] == src)) begin
            if (!match_found) begin
               match_found   = 1'b1;
               match_pending = fwd_pending[i];
            end
            if (!ready_found && !fwd_pending[i]) begin
               ready_found = 1'b1;
               ready_data  = fwd_data[DATA_SIZE*i +: DATA_SIZE];
            end
         end
      end
   end

   always_comb begin
      data   = (used && ready_found) ? ready_data : read_data;
      hazard = used && match_found && match_pending;
   end

endmodule

// File: rtl/read_stage.sv
// Second pipeline stage: decodes the instruction, reads and forwards operands,
// and holds the result in a one-entry valid/ready slot for the execute unit.
module read_stage
   import read_stage_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int NUM_FWD    = 2,
   parameter int COUNT_SIZE = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INSTRUCTION_SIZE-1:0]  instruction,
   output logic [REG_ADDR_SIZE-1:0]     read_address0,
   output logic [REG_ADDR_SIZE-1:0]     read_address1,
   input  logic [DATA_SIZE-1:0]         read_data0,
   input  logic [DATA_SIZE-1:0]         read_data1,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD-1:0]           fwd_pending,
   input  logic [NUM_FWD*3-1:0]         fwd_address,
   input  logic [NUM_FWD*DATA_SIZE-1:0] fwd_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OPCODE_SIZE-1:0]       opcode,
   output logic [DATA_SIZE-1:0]         operand0,
   output logic [DATA_SIZE-1:0]         operand1,
   output logic [DATA_SIZE-1:0]         operand2,
   output logic [VALUE_SIZE-1:0]        value,
   output logic [CONSTANT_SIZE-1:0]     constant,
   output logic [OFFSET_SIZE-1:0]       offset,
   output logic [CONDITION_SIZE-1:0]    condition,
   output logic [COUNT_SIZE-1:0]        hazard_count
);

   decode_t              dec;
   logic [DATA_SIZE-1:0] data0;
   logic [DATA_SIZE-1:0] data1;
   logic [DATA_SIZE-1:0] dest_ext;
   logic                 hazard0;
   logic                 hazard1;
   logic                 hazard;
   logic                 slot_free;
   logic                 accept;

   always_comb begin
      dec           = decode_instruction(instruction);
      read_address0 = dec.src0;
      read_address1 = dec.src1;
      dest_ext      = {{(DATA_SIZE-REG_ADDR_SIZE){1'b0}}, dec.dest};
   end

   read_stage_fwd_mux #(
      .DATA_SIZE (DATA_SIZE),
      .NUM_FWD   (NUM_FWD)
   ) u_fwd0 (
      .src         (dec.src0),
      .used        (dec.use0),
      .read_data   (read_data0),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_address (fwd_address),
      .fwd_data    (fwd_data),
      .data        (data0),
      .hazard      (hazard0)
   );

   read_stage_fwd_mux #(
      .DATA_SIZE (DATA_SIZE),
      .NUM_FWD   (NUM_FWD)
   ) u_fwd1 (
      .src         (dec.src1),
      .used        (dec.use1),
      .read_data   (read_data1),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_address (fwd_address),
      .fwd_data    (fwd_data),
      .data        (data1),
      .hazard      (hazard1)
   );

   // flush blocks acceptance but deliberately stays out of in_ready.
   always_comb begin
      hazard    = in_valid && (hazard0 || hazard1);
      slot_free = !out_valid || out_ready;
      in_ready  = slot_free && !hazard;
      accept    = in_valid && in_ready && !flush;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hazard_count <= '0;
      end else if (hazard && (hazard_count != {COUNT_SIZE{1'b1}})) begin
         hazard_count <= hazard_count + COUNT_SIZE'(1);
      end
   end

   // Fields an instruction type does not carry keep their previous contents.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         opcode    <= '0;
         operand0  <= '0;
         operand1  <= '0;
         operand2  <= '0;
         value     <= '0;
         constant  <= '0;
         offset    <= '0;
         condition <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         opcode    <= instruction[OPCODE_SELECT_MSB:OPCODE_SELECT_LSB];
         case (dec.kind)
            KIND_ARITH: begin
               operand0 <= dest_ext;
               operand1 <= data0;
               operand2 <= data1;
            end
            KIND_SHIFT: begin
               operand0 <= dest_ext;
               operand1 <= data0;
               value    <= instruction[VALUE_SIZE-1:0];
            end
            KIND_LOADSTORE: begin
               operand0 <= dest_ext;
               operand1 <= data0;
            end
            KIND_LOADC: begin
               operand0 <= dest_ext;
               constant <= instruction[CONSTANT_SIZE-1:0];
            end
            KIND_JMP: begin
               operand0 <= data0;
            end
            KIND_JMPR: begin
               operand0 <= data0;
               offset   <= instruction[OFFSET_SIZE-1:0];
            end
            KIND_JMPCOND: begin
               operand0  <= data0;
               operand1  <= data1;
               condition <= instruction[CONDITION_MSB:CONDITION_LSB];
            end
            default: begin
               operand0  <= data0;
               offset    <= instruction[OFFSET_SIZE-1:0];
               condition <= instruction[CONDITION_MSB:CONDITION_LSB];
            end
         endcase
      end else if (slot_free) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_read_stage.sv
// Directed bench for read_stage: decode, forwarding priority, load-use bubbles,
// backpressure, flush and a few instruction formats, with hand-computed results.
module tb_read_stage;

   localparam int DS = 32;
   localparam int NF = 2;
   localparam int CS = 16;

   logic           clock = 1'b0;
   logic           reset;
   logic           flush;
   logic           in_valid;
   logic           in_ready;
   logic [15:0]    instruction;
   logic [2:0]     read_address0;
   logic [2:0]     read_address1;
   logic [DS-1:0]  read_data0;
   logic [DS-1:0]  read_data1;
   logic [NF-1:0]  fwd_valid;
   logic [NF-1:0]  fwd_pending;
   logic [NF*3-1:0]  fwd_address;
   logic [NF*DS-1:0] fwd_data;
   logic           out_valid;
   logic           out_ready;
   logic [3:0]     opcode;
   logic [DS-1:0]  operand0;
   logic [DS-1:0]  operand1;
   logic [DS-1:0]  operand2;
   logic [5:0]     value;
   logic [7:0]     constant;
   logic [5:0]     offset;
   logic [2:0]     condition;
   logic [CS-1:0]  hazard_count;

   int total = 0;
   int bad   = 0;

   read_stage #(
      .DATA_SIZE  (DS),
      .NUM_FWD    (NF),
      .COUNT_SIZE (CS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .instruction   (instruction),
      .read_address0 (read_address0),
      .read_address1 (read_address1),
      .read_data0    (read_data0),
      .read_data1    (read_data1),
      .fwd_valid     (fwd_valid),
      .fwd_pending   (fwd_pending),
      .fwd_address   (fwd_address),
      .fwd_data      (fwd_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .opcode        (opcode),
      .operand0      (operand0),
      .operand1      (operand1),
      .operand2      (operand2),
      .value         (value),
      .constant      (constant),
      .offset        (offset),
      .condition     (condition),
      .hazard_count  (hazard_count)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [15:0] inst,
                                input logic [DS-1:0] rd0, input logic [DS-1:0] rd1);
      in_valid    = valid;
      instruction = inst;
      read_data0  = rd0;
      read_data1  = rd1;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset       = 1'b1;
      flush       = 1'b0;
      out_ready   = 1'b1;
      fwd_valid   = '0;
      fwd_pending = '0;
      fwd_address = '0;
      fwd_data    = '0;
      // ADD r3,r1,r2 presented while reset is held
      applyStimulus(1'b1, 16'h00CA, 32'd5, 32'd7);
      repeat (2) tick();
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      checkOutput("reset_hazard_count", 64'(hazard_count), 64'd0);
      checkOutput("reset_opcode", 64'(opcode), 64'd0);
      checkOutput("reset_operands", {operand0, operand1 | operand2}, 64'd0);
      checkOutput("reset_fields", 64'({value, constant, offset, condition}), 64'd0);

      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      checkOutput("idle_out_valid", 64'(out_valid), 64'd0);

      // plain ADD from register file
      applyStimulus(1'b1, 16'h00CA, 32'd5, 32'd7);
      #1;
      checkOutput("add_in_ready", 64'(in_ready), 64'd1);
      checkOutput("add_read_address0", 64'(read_address0), 64'd1);
      checkOutput("add_read_address1", 64'(read_address1), 64'd2);
      tick();
      checkOutput("add_out_valid", 64'(out_valid), 64'd1);
      checkOutput("add_operand0", 64'(operand0), 64'd3);
      checkOutput("add_operand1", 64'(operand1), 64'd5);
      checkOutput("add_operand2", 64'(operand2), 64'd7);
      checkOutput("add_opcode", 64'(opcode), 64'd0);

      // both sources forward r1; source 0 wins
      fwd_valid   = 2'b11;
      fwd_address = {3'd1, 3'd1};
      fwd_data    = {32'h22, 32'h11};
      tick();
      checkOutput("fwd_operand1", 64'(operand1), 64'h11);
      checkOutput("fwd_operand2", 64'(operand2), 64'd7);

      // load-use on r1 for three cycles
      fwd_valid   = 2'b01;
      fwd_pending = 2'b01;
      fwd_address = {3'd0, 3'd1};
      fwd_data    = {32'h0, 32'h55};
      for (int c = 1; c <= 3; c++) begin
         #1;
         checkOutput("lu_in_ready", 64'(in_ready), 64'd0);
         tick();
         checkOutput("lu_bubble", 64'(out_valid), 64'd0);
         checkOutput("lu_hazard_count", 64'(hazard_count), 64'(c));
      end
      fwd_pending = 2'b00;
      fwd_data    = {32'h0, 32'h99};
      #1;
      checkOutput("lu_release_in_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("lu_out_valid", 64'(out_valid), 64'd1);
      checkOutput("lu_operand1", 64'(operand1), 64'h99);
      checkOutput("lu_hazard_count_final", 64'(hazard_count), 64'd3);

      // backpressure with ADD r4,r1,r2 waiting
      fwd_valid = 2'b00;
      out_ready = 1'b0;
      applyStimulus(1'b1, 16'h010A, 32'hA, 32'hB);
      for (int c = 0; c < 4; c++) begin
         #1;
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
         tick();
         checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
         checkOutput("bp_operand0", 64'(operand0), 64'd3);
         checkOutput("bp_operand1", 64'(operand1), 64'h99);
         checkOutput("bp_hazard_count", 64'(hazard_count), 64'd3);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("bp_new_operand0", 64'(operand0), 64'd4);
      checkOutput("bp_new_operand1", 64'(operand1), 64'hA);
      checkOutput("bp_new_operand2", 64'(operand2), 64'hB);

      // flush alongside LOADC r2,0x5A, then the same LOADC again
      applyStimulus(1'b1, 16'hA25A, 32'h0, 32'h0);
      flush = 1'b1;
      #1;
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_operand0_held", 64'(operand0), 64'd4);
      flush = 1'b0;
      tick();
      checkOutput("loadc_out_valid", 64'(out_valid), 64'd1);
      checkOutput("loadc_opcode", 64'(opcode), 64'hA);
      checkOutput("loadc_constant", 64'(constant), 64'h5A);
      checkOutput("loadc_operand0", 64'(operand0), 64'd2);
      checkOutput("loadc_operand1_held", 64'(operand1), 64'hA);

      // SHL r5 by 0x2D
      applyStimulus(1'b1, 16'h416D, 32'h1234, 32'hDEAD);
      #1;
      checkOutput("shl_read_address0", 64'(read_address0), 64'd5);
      checkOutput("shl_read_address1", 64'(read_address1), 64'd0);
      tick();
      checkOutput("shl_opcode", 64'(opcode), 64'h4);
      checkOutput("shl_operand0", 64'(operand0), 64'd5);
      checkOutput("shl_operand1", 64'(operand1), 64'h1234);
      checkOutput("shl_operand2_held", 64'(operand2), 64'hB);
      checkOutput("shl_value", 64'(value), 64'h2D);
      checkOutput("shl_constant_held", 64'(constant), 64'h5A);

      // JMPRCOND cond=3 on r6, offset 0x15; only source 1 is valid
      applyStimulus(1'b1, 16'hF795, 32'h1, 32'h2);
      fwd_valid   = 2'b10;
      fwd_address = {3'd6, 3'd6};
      fwd_data    = {32'h77, 32'h66};
      #1;
      checkOutput("jrc_read_address0", 64'(read_address0), 64'd6);
      tick();
      checkOutput("jrc_opcode", 64'(opcode), 64'hF);
      checkOutput("jrc_operand0", 64'(operand0), 64'h77);
      checkOutput("jrc_offset", 64'(offset), 64'h15);
      checkOutput("jrc_condition", 64'(condition), 64'd3);
      checkOutput("jrc_operand1_held", 64'(operand1), 64'h1234);

      // youngest match pending blocks even though an older copy is ready
      fwd_valid   = 2'b11;
      fwd_pending = 2'b01;
      #1;
      checkOutput("prio_hazard_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      #1;
      checkOutput("prio_no_valid_in_ready", 64'(in_ready), 64'd1);
      tick();
      checkOutput("final_bubble", 64'(out_valid), 64'd0);
      checkOutput("final_hazard_count", 64'(hazard_count), 64'd3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
